// File: rtl/waffle_io_pkg.sv
// Shared I/O decode constants for the waffle SoC top level and the
// memory-mapped timer responder.
package waffle_io_pkg;

  localparam logic [15:0] SW_ADDR  = 16'd998;
  localparam logic [15:0] LED_ADDR = 16'd999;

  localparam logic [16:0] TMR_WIN = 17'd7;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_RLD_LO   = 3'd1;
  localparam logic [2:0] OFF_RLD_HI   = 3'd2;
  localparam logic [2:0] OFF_CNT_LO   = 3'd3;
  localparam logic [2:0] OFF_CNT_HI   = 3'd4;
  localparam logic [2:0] OFF_STATUS   = 3'd5;
  localparam logic [2:0] OFF_PRESCALE = 3'd6;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } timer_state_t;

endpackage

// File: rtl/waffle_timer_responder_prescaler.sv
// Prescaler: counts clk cycles and pulses tick every cmp+1 cycles.
// clr forces the count to zero and suppresses tick.
module waffle_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] cmp,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && !clr && (cnt_q == cmp);
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/waffle_timer_responder.sv
// Memory-mapped 16-bit down-counting timer on the CPU data bus,
// with sticky expiry flag and registered interrupt request.
module waffle_timer_responder
  import waffle_io_pkg::*;
#(
  parameter logic [15:0] BASE       = 16'd1000,
  parameter int          PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        hit,
  output logic        irq
);

  timer_state_t state_q, state_d;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [7:0]  rld_lo_q, rld_lo_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  snap_q, snap_d;
  logic        exp_q, exp_d;
  logic [7:0]  dout_q, dout_d;
  logic        hit_q, hit_d;
  logic        irq_q, irq_d;

  logic [PRESCALE_W-1:0] presc_q, presc_d;

  logic [16:0] rel;
  logic        in_win;
  logic [2:0]  off;
  logic        wr;
  logic        wr_ctrl, wr_rlo, wr_rhi;
  logic        wr_stat, wr_psc, rd_lo;
  logic        run, tick, expire;
  logic [7:0]  rdata;

  // Below-BASE addresses wrap to a huge offset and miss the window.
  assign rel     = {1'b0, addr} - {1'b0, BASE};
  assign in_win  = rel < TMR_WIN;
  assign off     = rel[2:0];
  assign wr      = we && in_win;
  assign wr_ctrl = wr && (off == OFF_CTRL);
  assign wr_rlo  = wr && (off == OFF_RLD_LO);
  assign wr_rhi  = wr && (off == OFF_RLD_HI);
  assign wr_stat = wr && (off == OFF_STATUS);
  assign wr_psc  = wr && (off == OFF_PRESCALE);
  assign rd_lo   = !we && in_win && (off == OFF_CNT_LO);
  assign run     = (state_q == RUNNING);

  waffle_prescaler #(
    .W (PRESCALE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .clr   (!run || wr_rhi),
    .cmp   (presc_q),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    rld_lo_d = rld_lo_q;
    reload_d = reload_q;
    count_d  = count_q;
    snap_d   = snap_q;
    exp_d    = exp_q;
    presc_d  = presc_q;
    expire   = tick && (count_q == 16'd0);
    if (tick) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else if (ctrl_q[CTRL_AUTO]) begin
        count_d = reload_q;
      end
    end
    if (expire && !ctrl_q[CTRL_AUTO]) begin
      ctrl_d[CTRL_EN] = 1'b0;
    end
    if (wr_ctrl) ctrl_d = din[2:0];
    if (wr_rlo)  rld_lo_d = din;
    if (wr_rhi) begin
      reload_d = {din, rld_lo_q};
      count_d  = {din, rld_lo_q};
    end
    if (wr_stat && din[0]) exp_d = 1'b0;
    if (expire) exp_d = 1'b1;
    if (wr_psc) presc_d = PRESCALE_W'(din);
    if (rd_lo)  snap_d = count_q[15:8];
    unique case (state_q)
      STOPPED: begin
        if (ctrl_q[CTRL_EN]) state_d = RUNNING;
      end
      RUNNING: begin
        if (!ctrl_q[CTRL_EN] ||
            (expire && !ctrl_q[CTRL_AUTO])) begin
          state_d = STOPPED;
        end
      end
      default: state_d = STOPPED;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL:     rdata = {5'd0, ctrl_q};
      OFF_RLD_LO:   rdata = rld_lo_q;
      OFF_RLD_HI:   rdata = reload_q[15:8];
      OFF_CNT_LO:   rdata = count_q[7:0];
      OFF_CNT_HI:   rdata = snap_q;
      OFF_STATUS:   rdata = {7'd0, exp_q};
      OFF_PRESCALE: rdata = 8'(presc_q);
      default:      rdata = '0;
    endcase
    dout_d = in_win ? rdata : 8'd0;
    hit_d  = in_win;
    irq_d  = exp_q && ctrl_q[CTRL_IE];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= STOPPED;
      ctrl_q   <= '0;
      rld_lo_q <= '0;
      reload_q <= '0;
      count_q  <= '0;
      snap_q   <= '0;
      exp_q    <= 1'b0;
      presc_q  <= '0;
      dout_q   <= '0;
      hit_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      rld_lo_q <= rld_lo_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      snap_q   <= snap_d;
      exp_q    <= exp_d;
      presc_q  <= presc_d;
      dout_q   <= dout_d;
      hit_q    <= hit_d;
      irq_q    <= irq_d;
    end
  end

  assign dout = dout_q;
  assign hit  = hit_q;
  assign irq  = irq_q;

endmodule
